// File: rtl/lock_access_sequencer.sv
// Keypad sequencer for the six-digit lock: collects BCD digits, checks them against the stored
// password, counts failures, times lockout and the unlock window, and sequences password writes.
module lock_access_sequencer #(
    parameter int unsigned MAX_FAIL       = 3,
    parameter int unsigned LOCKOUT_CYCLES = 1000,
    parameter int unsigned OPEN_CYCLES    = 500
) (
    input  logic        i_clk,
    input  logic        i_clr,
    input  logic        i_m,
    input  logic        i_key_valid,
    input  logic [3:0]  i_key_digit,
    input  logic        i_key_enter,
    input  logic        i_key_cancel,
    input  logic [23:0] i_pwd,
    output logic        o_pwd_we,
    output logic [23:0] o_pwd_wdata,
    output logic [23:0] o_entry_buf,
    output logic [2:0]  o_digit_cnt,
    output logic        o_unlock,
    output logic        o_alarm,
    output logic        o_res_ok,
    output logic        o_res_fail,
    output logic [2:0]  o_fail_cnt,
    output logic [2:0]  o_state
);

    localparam int unsigned MaxCycles = (LOCKOUT_CYCLES > OPEN_CYCLES) ? LOCKOUT_CYCLES
                                                                        : OPEN_CYCLES;
    localparam int unsigned TimerW = (MaxCycles > 2) ? $clog2(MaxCycles) : 1;
    localparam logic [TimerW-1:0] OpenLoad = TimerW'(OPEN_CYCLES - 1);
    localparam logic [TimerW-1:0] LockLoad = TimerW'(LOCKOUT_CYCLES - 1);
    localparam logic [2:0] MaxFail = 3'(MAX_FAIL);

    typedef enum logic [2:0] {
        StIdle    = 3'd0,
        StEntry   = 3'd1,
        StCheck   = 3'd2,
        StOpen    = 3'd3,
        StSet     = 3'd4,
        StLockout = 3'd5
    } state_e;

    state_e             r_state, w_state_d;
    logic [23:0]        r_buf, w_buf_d;
    logic [2:0]         r_cnt, w_cnt_d;
    logic [2:0]         r_fail_cnt, w_fail_cnt_d;
    logic [TimerW-1:0]  r_timer, w_timer_d;
    logic               r_pwd_we, w_pwd_we_d;
    logic [23:0]        r_pwd_wdata, w_pwd_wdata_d;
    logic               r_res_ok, w_res_ok_d;
    logic               r_res_fail, w_res_fail_d;

    // Strobe priority: cancel > enter > digit; lower strobes are dropped.
    logic        w_cancel, w_enter, w_digit_ok, w_room, w_timer_zero, w_match;
    logic [2:0]  w_fail_inc;
    logic [23:0] w_buf_shift;

    assign w_cancel     = i_key_cancel;
    assign w_enter      = i_key_enter && !i_key_cancel;
    assign w_digit_ok   = i_key_valid && !i_key_enter && !i_key_cancel && (i_key_digit <= 4'd9);
    assign w_room       = (r_cnt < 3'd6);
    assign w_timer_zero = (r_timer == '0);
    assign w_match      = (r_cnt == 3'd6) && (r_buf == i_pwd);
    assign w_fail_inc   = r_fail_cnt + 3'd1;
    assign w_buf_shift  = {r_buf[19:0], i_key_digit};

    always_comb begin
        w_state_d     = r_state;
        w_buf_d       = r_buf;
        w_cnt_d       = r_cnt;
        w_fail_cnt_d  = r_fail_cnt;
        w_timer_d     = r_timer;
        w_pwd_we_d    = 1'b0;
        w_pwd_wdata_d = r_pwd_wdata;
        w_res_ok_d    = 1'b0;
        w_res_fail_d  = 1'b0;

        case (r_state)
            StIdle: begin
                if (w_digit_ok && !i_m) begin
                    w_buf_d   = w_buf_shift;
                    w_cnt_d   = r_cnt + 3'd1;
                    w_state_d = StEntry;
                end
            end
            StEntry: begin
                if (w_cancel) begin
                    w_buf_d   = '0;
                    w_cnt_d   = '0;
                    w_state_d = StIdle;
                end else if (w_enter) begin
                    w_state_d = StCheck;
                end else if (w_digit_ok && w_room) begin
                    w_buf_d = w_buf_shift;
                    w_cnt_d = r_cnt + 3'd1;
                end
            end
            StCheck: begin
                w_buf_d = '0;
                w_cnt_d = '0;
                if (w_match) begin
                    w_res_ok_d   = 1'b1;
                    w_fail_cnt_d = '0;
                    w_timer_d    = OpenLoad;
                    w_state_d    = StOpen;
                end else begin
                    w_res_fail_d = 1'b1;
                    w_fail_cnt_d = w_fail_inc;
                    if (w_fail_inc == MaxFail) begin
                        w_timer_d = LockLoad;
                        w_state_d = StLockout;
                    end else begin
                        w_state_d = StIdle;
                    end
                end
            end
            StOpen: begin
                if (w_cancel) begin
                    w_buf_d   = '0;
                    w_cnt_d   = '0;
                    w_state_d = StIdle;
                end else if (w_digit_ok && i_m) begin
                    w_buf_d   = w_buf_shift;
                    w_cnt_d   = 3'd1;
                    w_timer_d = OpenLoad;
                    w_state_d = StSet;
                end else if (w_timer_zero) begin
                    w_buf_d   = '0;
                    w_cnt_d   = '0;
                    w_state_d = StIdle;
                end else begin
                    w_timer_d = r_timer - 1'b1;
                end
            end
            StSet: begin
                if (w_cancel || w_enter) begin
                    if (w_enter && (r_cnt == 3'd6)) begin
                        w_pwd_we_d    = 1'b1;
                        w_pwd_wdata_d = r_buf;
                    end
                    w_buf_d   = '0;
                    w_cnt_d   = '0;
                    w_state_d = StIdle;
                end else if (w_digit_ok && w_room) begin
                    w_buf_d   = w_buf_shift;
                    w_cnt_d   = r_cnt + 3'd1;
                    w_timer_d = OpenLoad;
                end else if (w_timer_zero) begin
                    w_buf_d   = '0;
                    w_cnt_d   = '0;
                    w_state_d = StIdle;
                end else begin
                    w_timer_d = r_timer - 1'b1;
                end
            end
            StLockout: begin
                if (w_timer_zero) begin
                    w_fail_cnt_d = '0;
                    w_buf_d      = '0;
                    w_cnt_d      = '0;
                    w_state_d    = StIdle;
                end else begin
                    w_timer_d = r_timer - 1'b1;
                end
            end
            default: begin
                w_buf_d   = '0;
                w_cnt_d   = '0;
                w_state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_clr) begin
            r_state     <= StIdle;
            r_buf       <= '0;
            r_cnt       <= '0;
            r_fail_cnt  <= '0;
            r_timer     <= '0;
            r_pwd_we    <= 1'b0;
            r_pwd_wdata <= '0;
            r_res_ok    <= 1'b0;
            r_res_fail  <= 1'b0;
        end else begin
            r_state     <= w_state_d;
            r_buf       <= w_buf_d;
            r_cnt       <= w_cnt_d;
            r_fail_cnt  <= w_fail_cnt_d;
            r_timer     <= w_timer_d;
            r_pwd_we    <= w_pwd_we_d;
            r_pwd_wdata <= w_pwd_wdata_d;
            r_res_ok    <= w_res_ok_d;
            r_res_fail  <= w_res_fail_d;
        end
    end

    assign o_pwd_we    = r_pwd_we;
    assign o_pwd_wdata = r_pwd_wdata;
    assign o_entry_buf = r_buf;
    assign o_digit_cnt = r_cnt;
    assign o_unlock    = (r_state == StOpen) || (r_state == StSet);
    assign o_alarm     = (r_state == StLockout);
    assign o_res_ok    = r_res_ok;
    assign o_res_fail  = r_res_fail;
    assign o_fail_cnt  = r_fail_cnt;
    assign o_state     = r_state;

endmodule

// File: tb/tb_lock_access_sequencer.sv
// Directed bench for lock_access_sequencer: unlock, failure, lockout, password set,
// strobe priority and mid-operation reset, with hand-computed expectations.
module tb_lock_access_sequencer;

    logic        clk = 1'b0;
    logic        clr, m, kv, ke, kc;
    logic [3:0]  kd;
    logic [23:0] pwd;
    logic        pwd_we, unlock, alarm, res_ok, res_fail;
    logic [23:0] pwd_wdata, entry_buf;
    logic [2:0]  digit_cnt, fail_cnt, state;

    int checks   = 0;
    int failures = 0;

    lock_access_sequencer dut (
        .i_clk       (clk),
        .i_clr       (clr),
        .i_m         (m),
        .i_key_valid (kv),
        .i_key_digit (kd),
        .i_key_enter (ke),
        .i_key_cancel(kc),
        .i_pwd       (pwd),
        .o_pwd_we    (pwd_we),
        .o_pwd_wdata (pwd_wdata),
        .o_entry_buf (entry_buf),
        .o_digit_cnt (digit_cnt),
        .o_unlock    (unlock),
        .o_alarm     (alarm),
        .o_res_ok    (res_ok),
        .o_res_fail  (res_fail),
        .o_fail_cnt  (fail_cnt),
        .o_state     (state)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [3:0] d);
        kv = 1'b1;
        kd = d;
        tick();
        kv = 1'b0;
    endtask

    task automatic press_code(input logic [23:0] c, input int n);
        for (int i = 0; i < n; i++) press(c[23 - 4*i -: 4]);
    endtask

    task automatic hit_enter();
        ke = 1'b1;
        tick();
        ke = 1'b0;
    endtask

    task automatic hit_cancel();
        kc = 1'b1;
        tick();
        kc = 1'b0;
    endtask

    task automatic do_reset();
        clr = 1'b1;
        tick();
        tick();
        clr = 1'b0;
    endtask

    // Correct code, enter, CHECK cycle: leaves the DUT in its first OPEN cycle.
    task automatic unlock_now();
        m = 1'b0;
        press_code(24'h123456, 6);
        hit_enter();
        tick();
    endtask

    task automatic test_reset();
        logic [61:0] outs;
        do_reset();
        outs = {pwd_we, pwd_wdata, entry_buf, digit_cnt, unlock, alarm, res_ok, res_fail,
                fail_cnt, state};
        checks++;
        if (outs !== 62'd0) begin
            failures++;
            $display("FAIL reset_outputs: got %h want 0", outs);
        end
    endtask

    task automatic test_unlock();
        int n;
        m = 1'b0;
        press_code(24'h123456, 6);
        checks++;
        if (state !== 3'd1 || digit_cnt !== 3'd6 || entry_buf !== 24'h123456) begin
            failures++;
            $display("FAIL unlock_entry: got st=%0d cnt=%0d buf=%h want 1/6/123456",
                     state, digit_cnt, entry_buf);
        end
        hit_enter();
        checks++;
        if (state !== 3'd2 || res_ok !== 1'b0) begin
            failures++;
            $display("FAIL unlock_check_cycle: got st=%0d ok=%b want 2/0", state, res_ok);
        end
        tick();
        checks++;
        if (res_ok !== 1'b1 || unlock !== 1'b1 || state !== 3'd3 || res_fail !== 1'b0) begin
            failures++;
            $display("FAIL unlock_result: got ok=%b unl=%b st=%0d fail=%b want 1/1/3/0",
                     res_ok, unlock, state, res_fail);
        end
        n = 0;
        while (unlock && n < 2000) begin
            tick();
            n++;
        end
        checks++;
        if (n !== 500) begin
            failures++;
            $display("FAIL unlock_window_len: got %0d want 500", n);
        end
        checks++;
        if (state !== 3'd0 || unlock !== 1'b0 || res_ok !== 1'b0) begin
            failures++;
            $display("FAIL unlock_expire: got st=%0d unl=%b ok=%b want 0/0/0",
                     state, unlock, res_ok);
        end
    endtask

    task automatic test_fail();
        m = 1'b0;
        press_code(24'h123000, 3);
        hit_enter();
        tick();
        checks++;
        if (res_fail !== 1'b1 || res_ok !== 1'b0 || fail_cnt !== 3'd1 || state !== 3'd0 ||
            entry_buf !== 24'h0 || digit_cnt !== 3'd0) begin
            failures++;
            $display("FAIL short_entry: got rf=%b ok=%b fc=%0d st=%0d buf=%h cnt=%0d want 1/0/1/0/0/0",
                     res_fail, res_ok, fail_cnt, state, entry_buf, digit_cnt);
        end
        press(4'd7);
        press(4'd8);
        checks++;
        if (state !== 3'd1 || entry_buf !== 24'h000078 || digit_cnt !== 3'd2 ||
            res_fail !== 1'b0) begin
            failures++;
            $display("FAIL mid_entry: got st=%0d buf=%h cnt=%0d rf=%b want 1/000078/2/0",
                     state, entry_buf, digit_cnt, res_fail);
        end
        hit_cancel();
        checks++;
        if (state !== 3'd0 || fail_cnt !== 3'd1 || entry_buf !== 24'h0 || digit_cnt !== 3'd0) begin
            failures++;
            $display("FAIL cancel_entry: got st=%0d fc=%0d buf=%h cnt=%0d want 0/1/0/0",
                     state, fail_cnt, entry_buf, digit_cnt);
        end
    endtask

    task automatic test_lockout();
        int n;
        int bad;
        do_reset();
        for (int k = 1; k <= 3; k++) begin
            press_code(24'h999999, 6);
            hit_enter();
            tick();
            if (k < 3) begin
                checks++;
                if (fail_cnt !== 3'(k) || state !== 3'd0 || alarm !== 1'b0) begin
                    failures++;
                    $display("FAIL wrong_code_%0d: got fc=%0d st=%0d al=%b want %0d/0/0",
                             k, fail_cnt, state, alarm, k);
                end
            end
        end
        checks++;
        if (alarm !== 1'b1 || state !== 3'd5 || fail_cnt !== 3'd3 || res_fail !== 1'b1) begin
            failures++;
            $display("FAIL lockout_enter: got al=%b st=%0d fc=%0d rf=%b want 1/5/3/1",
                     alarm, state, fail_cnt, res_fail);
        end
        n = 0;
        bad = 0;
        while (alarm && n < 5000) begin
            kv = 1'b1;
            kd = 4'(n % 10);
            ke = (n % 37 == 0);
            kc = (n % 53 == 0);
            tick();
            kv = 1'b0;
            ke = 1'b0;
            kc = 1'b0;
            n++;
            if (alarm && (digit_cnt !== 3'd0 || state !== 3'd5)) bad++;
        end
        checks++;
        if (n !== 1000) begin
            failures++;
            $display("FAIL lockout_len: got %0d want 1000", n);
        end
        checks++;
        if (bad !== 0) begin
            failures++;
            $display("FAIL lockout_keys_ignored: got %0d disturbed cycles want 0", bad);
        end
        checks++;
        if (alarm !== 1'b0 || fail_cnt !== 3'd0 || state !== 3'd0 || digit_cnt !== 3'd0) begin
            failures++;
            $display("FAIL lockout_exit: got al=%b fc=%0d st=%0d cnt=%0d want 0/0/0/0",
                     alarm, fail_cnt, state, digit_cnt);
        end
        unlock_now();
        checks++;
        if (res_ok !== 1'b1 || state !== 3'd3) begin
            failures++;
            $display("FAIL unlock_after_lockout: got ok=%b st=%0d want 1/3", res_ok, state);
        end
        hit_cancel();
        checks++;
        if (state !== 3'd0 || unlock !== 1'b0) begin
            failures++;
            $display("FAIL relock_cancel: got st=%0d unl=%b want 0/0", state, unlock);
        end
    endtask

    task automatic test_set();
        unlock_now();
        m = 1'b1;
        press(4'd6);
        checks++;
        if (state !== 3'd4 || unlock !== 1'b1 || digit_cnt !== 3'd1) begin
            failures++;
            $display("FAIL set_enter: got st=%0d unl=%b cnt=%0d want 4/1/1",
                     state, unlock, digit_cnt);
        end
        press_code(24'h543210, 5);
        checks++;
        if (entry_buf !== 24'h654321 || digit_cnt !== 3'd6) begin
            failures++;
            $display("FAIL set_buffer: got buf=%h cnt=%0d want 654321/6", entry_buf, digit_cnt);
        end
        hit_enter();
        checks++;
        if (pwd_we !== 1'b1 || pwd_wdata !== 24'h654321 || state !== 3'd0) begin
            failures++;
            $display("FAIL set_write: got we=%b wd=%h st=%0d want 1/654321/0",
                     pwd_we, pwd_wdata, state);
        end
        tick();
        checks++;
        if (pwd_we !== 1'b0) begin
            failures++;
            $display("FAIL set_write_pulse: got we=%b want 0", pwd_we);
        end
        unlock_now();
        m = 1'b1;
        press_code(24'h987650, 5);
        checks++;
        if (state !== 3'd4 || digit_cnt !== 3'd5) begin
            failures++;
            $display("FAIL set_short_entry: got st=%0d cnt=%0d want 4/5", state, digit_cnt);
        end
        hit_enter();
        checks++;
        if (pwd_we !== 1'b0 || state !== 3'd0 || entry_buf !== 24'h0 || fail_cnt !== 3'd0) begin
            failures++;
            $display("FAIL set_short_nowrite: got we=%b st=%0d buf=%h fc=%0d want 0/0/0/0",
                     pwd_we, state, entry_buf, fail_cnt);
        end
        m = 1'b0;
    endtask

    task automatic test_priority();
        m = 1'b0;
        press(4'd1);
        kv = 1'b1;
        kd = 4'd5;
        ke = 1'b1;
        kc = 1'b1;
        tick();
        kv = 1'b0;
        ke = 1'b0;
        kc = 1'b0;
        checks++;
        if (state !== 3'd0 || digit_cnt !== 3'd0 || entry_buf !== 24'h0) begin
            failures++;
            $display("FAIL cancel_wins: got st=%0d cnt=%0d buf=%h want 0/0/0",
                     state, digit_cnt, entry_buf);
        end
        tick();
        checks++;
        if (res_fail !== 1'b0 || fail_cnt !== 3'd0) begin
            failures++;
            $display("FAIL cancel_no_fail: got rf=%b fc=%0d want 0/0", res_fail, fail_cnt);
        end
        press(4'd1);
        press(4'd2);
        press(4'hA);
        checks++;
        if (digit_cnt !== 3'd2 || entry_buf !== 24'h000012) begin
            failures++;
            $display("FAIL illegal_digit: got cnt=%0d buf=%h want 2/000012", digit_cnt, entry_buf);
        end
        press_code(24'h345670, 5);
        press(4'hA);
        checks++;
        if (digit_cnt !== 3'd6 || entry_buf !== 24'h123456) begin
            failures++;
            $display("FAIL seventh_digit: got cnt=%0d buf=%h want 6/123456", digit_cnt, entry_buf);
        end
        kv = 1'b1;
        kd = 4'd9;
        ke = 1'b1;
        tick();
        kv = 1'b0;
        ke = 1'b0;
        checks++;
        if (state !== 3'd2 || entry_buf !== 24'h123456) begin
            failures++;
            $display("FAIL enter_beats_digit: got st=%0d buf=%h want 2/123456", state, entry_buf);
        end
        tick();
        checks++;
        if (res_ok !== 1'b1 || state !== 3'd3) begin
            failures++;
            $display("FAIL enter_beats_digit_ok: got ok=%b st=%0d want 1/3", res_ok, state);
        end
        hit_cancel();
    endtask

    task automatic test_reset_mid();
        logic [61:0] outs;
        do_reset();
        for (int k = 0; k < 3; k++) begin
            press_code(24'h999999, 6);
            hit_enter();
            tick();
        end
        for (int k = 0; k < 5; k++) tick();
        checks++;
        if (alarm !== 1'b1) begin
            failures++;
            $display("FAIL mid_lockout_setup: got al=%b want 1", alarm);
        end
        clr = 1'b1;
        tick();
        clr = 1'b0;
        outs = {pwd_we, pwd_wdata, entry_buf, digit_cnt, unlock, alarm, res_ok, res_fail,
                fail_cnt, state};
        checks++;
        if (outs !== 62'd0) begin
            failures++;
            $display("FAIL reset_mid_lockout: got %h want 0", outs);
        end
        unlock_now();
        m = 1'b1;
        press_code(24'h111111, 6);
        checks++;
        if (state !== 3'd4 || digit_cnt !== 3'd6) begin
            failures++;
            $display("FAIL mid_set_setup: got st=%0d cnt=%0d want 4/6", state, digit_cnt);
        end
        clr = 1'b1;
        ke = 1'b1;
        tick();
        clr = 1'b0;
        ke = 1'b0;
        outs = {pwd_we, pwd_wdata, entry_buf, digit_cnt, unlock, alarm, res_ok, res_fail,
                fail_cnt, state};
        checks++;
        if (outs !== 62'd0) begin
            failures++;
            $display("FAIL reset_mid_set: got %h want 0", outs);
        end
        tick();
        checks++;
        if (pwd_we !== 1'b0 || state !== 3'd0) begin
            failures++;
            $display("FAIL reset_mid_set_nowrite: got we=%b st=%0d want 0/0", pwd_we, state);
        end
        m = 1'b0;
    endtask

    initial begin
        clr = 1'b1;
        m   = 1'b0;
        kv  = 1'b0;
        kd  = 4'd0;
        ke  = 1'b0;
        kc  = 1'b0;
        pwd = 24'h123456;
        test_reset();
        test_unlock();
        test_fail();
        test_lockout();
        test_set();
        test_priority();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
